// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep sequencer: state codes and default
// timing for a 50 MHz clock.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ACOMODA  = 4'd1,
    MEDE     = 4'd2,
    AGUARDA  = 4'd3,
    REGISTRA = 4'd4,
    PROXIMA  = 4'd5
  } estado_t;

  localparam int T_ACOMODA_50M = 25_000_000;
  localparam int T_TIMEOUT_50M = 5_000_000;

  // Bits needed for a timer that must reach max(a, b) - 1.
  function automatic int largura_timer(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic synchronous modulo counter; wraps to zero when Q reaches limite.
module contador_m #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic [W-1:0] Q,
  output logic         fim
);

  logic [W-1:0] r_q;

  assign Q   = r_q;
  assign fim = (r_q == limite);

  always_ff @(posedge clock) begin
    if (zera) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= fim ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/controle_varredura_sonar.sv
// Sonar sweep sequencer: moves the servo back and forth, waits for it to
// settle, triggers one distance measurement per position and flags the sample.
module controle_varredura_sonar
  import sonar_pkg::*;
#(
  parameter int N_POSICOES = 8,
  parameter int W_POS      = 3,
  parameter int T_ACOMODA  = T_ACOMODA_50M,
  parameter int T_TIMEOUT  = T_TIMEOUT_50M
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             fim_medida,
  output logic [W_POS-1:0] posicao,
  output logic             medir,
  output logic             registra,
  output logic             timeout_medida,
  output logic             direcao,
  output logic [3:0]       db_estado
);

  localparam int W_TIMER = largura_timer(T_ACOMODA, T_TIMEOUT);
  localparam logic [W_TIMER-1:0] LIM_ACOMODA = W_TIMER'(T_ACOMODA - 1);
  localparam logic [W_TIMER-1:0] LIM_TIMEOUT = W_TIMER'(T_TIMEOUT - 1);
  localparam logic [W_POS-1:0]   POS_MAX     = W_POS'(N_POSICOES - 1);

  estado_t            r_estado;
  estado_t            w_proximo;
  logic [W_POS-1:0]   r_posicao;
  logic               r_direcao;
  logic               r_timeout;
  logic               w_conta;
  logic               w_zera;
  logic [W_TIMER-1:0] w_limite;
  logic [W_TIMER-1:0] w_timer;
  logic               w_fim_timer;

  // One timer shared by the settle and measurement-wait states.
  contador_m #(.W(W_TIMER)) u_timer (
    .clock  (clock),
    .zera   (w_zera),
    .conta  (w_conta),
    .limite (w_limite),
    .Q      (w_timer),
    .fim    (w_fim_timer)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Dropping ligar parks the sweep from any active state.
  always_comb begin
    w_proximo = r_estado;
    if (r_estado != INICIAL && !ligar) begin
      w_proximo = INICIAL;
    end else begin
      unique case (r_estado)
        INICIAL:  if (ligar) w_proximo = ACOMODA;
        ACOMODA:  if (w_fim_timer) w_proximo = MEDE;
        MEDE:     w_proximo = AGUARDA;
        AGUARDA:  if (fim_medida || w_fim_timer) w_proximo = REGISTRA;
        REGISTRA: w_proximo = PROXIMA;
        PROXIMA:  w_proximo = ACOMODA;
        default:  w_proximo = INICIAL;
      endcase
    end
  end

  always_comb begin
    medir     = (r_estado == MEDE);
    registra  = (r_estado == REGISTRA);
    w_conta   = (r_estado == ACOMODA) || (r_estado == AGUARDA);
    w_zera    = reset || !w_conta;
    w_limite  = (r_estado == ACOMODA) ? LIM_ACOMODA : LIM_TIMEOUT;
    db_estado = r_estado;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_posicao <= '0;
      r_direcao <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_estado == INICIAL) begin
        r_posicao <= '0;
        r_direcao <= 1'b0;
      end else if (r_estado == PROXIMA && ligar) begin
        if (!r_direcao) begin
          if (r_posicao == POS_MAX) begin
            r_direcao <= 1'b1;
            r_posicao <= r_posicao - 1'b1;
          end else begin
            r_posicao <= r_posicao + 1'b1;
          end
        end else begin
          if (r_posicao == '0) begin
            r_direcao <= 1'b0;
            r_posicao <= r_posicao + 1'b1;
          end else begin
            r_posicao <= r_posicao - 1'b1;
          end
        end
      end
      // A completed measurement takes priority over the timeout.
      if (r_estado == AGUARDA && w_proximo == REGISTRA) begin
        r_timeout <= !fim_medida;
      end
    end
  end

  assign posicao        = r_posicao;
  assign direcao        = r_direcao;
  assign timeout_medida = r_timeout;

endmodule

// File: tb/tb_controle_varredura_sonar.sv
// Directed/random bench for the sonar sweep sequencer against a sample-level
// model of the sweep order and per-sample timing.
module tb_controle_varredura_sonar;

  localparam int N  = 4;
  localparam int WP = 2;
  localparam int TA = 4;
  localparam int TT = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          ligar;
  logic          fim_medida;
  logic [WP-1:0] posicao;
  logic          medir;
  logic          registra;
  logic          timeout_medida;
  logic          direcao;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;
  int k = 0;

  controle_varredura_sonar #(
    .N_POSICOES (N),
    .W_POS      (WP),
    .T_ACOMODA  (TA),
    .T_TIMEOUT  (TT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar          (ligar),
    .fim_medida     (fim_medida),
    .posicao        (posicao),
    .medir          (medir),
    .registra       (registra),
    .timeout_medida (timeout_medida),
    .direcao        (direcao),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample k of a sweep visits 0,1,..,N-1,N-2,..,1,0,1,... (period 2(N-1)).
  function automatic int pos_esperada(input int idx);
    int p;
    p = idx % (2 * (N - 1));
    return (p < N) ? p : 2 * (N - 1) - p;
  endfunction

  function automatic int dir_esperada(input int idx);
    int p;
    p = idx % (2 * (N - 1));
    return ((p >= N) || (p == 0 && idx > 0)) ? 1 : 0;
  endfunction

  // Starts in the first settle cycle; d = AGUARDA cycle carrying fim_medida
  // (0 = never), hold = fim_medida high from MEDE until registra.
  task automatic amostra(input int d, input bit hold);
    int n, w, pulsos, exp_w, exp_to;
    n = 0;
    while (!medir && n < 200) begin
      tick();
      n++;
    end
    check("lat_medir", n, TA);
    check("estado_mede", db_estado, 2);
    fim_medida = hold;
    w = 0;
    pulsos = 0;
    do begin
      tick();
      w++;
      if (medir) pulsos++;
      if (!registra) fim_medida = hold || (d != 0 && w == d);
    end while (!registra && w < 200);
    fim_medida = 1'b0;
    exp_w  = hold ? 2 : ((d != 0 && d <= TT) ? d + 1 : TT + 1);
    exp_to = (!hold && !(d != 0 && d <= TT)) ? 1 : 0;
    check("lat_registra", w, exp_w);
    check("medir_unico", pulsos, 0);
    check("posicao", posicao, pos_esperada(k));
    check("direcao", direcao, dir_esperada(k));
    check("timeout", timeout_medida, exp_to);
    tick();
    check("registra_1ciclo", registra, 0);
    check("estado_proxima", db_estado, 5);
    check("timeout_mantido", timeout_medida, exp_to);
    tick();
    check("estado_acomoda", db_estado, 1);
    k++;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    ligar = 1'b0;
    fim_medida = 1'b0;
    tick();
    tick();
    check("rst_posicao", posicao, 0);
    check("rst_medir", medir, 0);
    check("rst_registra", registra, 0);
    check("rst_timeout", timeout_medida, 0);
    check("rst_direcao", direcao, 0);
    check("rst_estado", db_estado, 0);
    reset = 1'b0;
    tick();
    tick();
    check("parado_inicial", db_estado, 0);

    ligar = 1'b1;
    tick();
    check("sai_inicial", db_estado, 1);
    for (int i = 0; i < 8; i++) amostra(3, 1'b0);

    amostra(0, 1'b0);
    amostra(3, 1'b0);
    amostra(TT, 1'b0);
    amostra(TT + 1, 1'b0);
    amostra(TT, 1'b0);
    amostra(1, 1'b1);
    amostra(1, 1'b1);
    for (int i = 0; i < 10; i++) amostra(int'($urandom_range(0, TT + 2)), 1'b0);

    n = 0;
    while (pos_esperada(k) != 2 && n < 10) begin
      amostra(int'($urandom_range(1, TT)), 1'b0);
      n++;
    end
    check("pos_antes_queda", posicao, 2);
    tick();
    ligar = 1'b0;
    tick();
    check("queda_estado", db_estado, 0);
    check("queda_medir", medir, 0);
    check("queda_registra", registra, 0);
    tick();
    check("queda_posicao", posicao, 0);
    check("queda_direcao", direcao, 0);
    tick();
    tick();
    check("queda_parado", db_estado, 0);

    ligar = 1'b1;
    k = 0;
    tick();
    check("religa_estado", db_estado, 1);
    amostra(3, 1'b0);
    amostra(3, 1'b0);
    amostra(0, 1'b0);

    n = 0;
    while (!medir && n < 200) begin
      tick();
      n++;
    end
    check("lat_medir_pre_rst", n, TA);
    tick();
    tick();
    check("em_aguarda", db_estado, 3);
    reset = 1'b1;
    tick();
    check("rst2_estado", db_estado, 0);
    check("rst2_posicao", posicao, 0);
    check("rst2_direcao", direcao, 0);
    check("rst2_timeout", timeout_medida, 0);
    check("rst2_medir", medir, 0);
    check("rst2_registra", registra, 0);
    reset = 1'b0;
    ligar = 1'b0;
    tick();
    check("rst2_parado", db_estado, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
